// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter
//   Shares the single HPS virtual-disk channel between the X68000 image
//   requesters (slot 0 FDD0, 1 FDD1, 2 SASI, 3 SRAM). Pending sector requests
//   are round-robin arbitrated. The winner's LBA and read/write strobe are
//   presented to hps_io. sd_ack and the buffer write data are routed to the
//   granted slot only, and a one-cycle completion pulse is returned.
//
//   Optional feature: define SDARB_TIMEOUT_EN to abort a transaction that has
//   not finished TIMEOUT cycles after issue. The abort pulses req_err instead
//   of req_done. Without it, req_err is tied to 0 and the block waits for
//   sd_ack indefinitely.
//
// Ports
//   clk_sys       system clock
//   reset         asynchronous, active-high reset
//   req_lba       per-slot sector LBA, slot i at [32i+31:32i]
//   req_rd/req_wr per-slot request levels, held until req_done
//   req_buff_din  per-slot write data for the HPS buffer, slot i at [8i+7:8i]
//   req_ack       sd_ack routed to the granted slot
//   req_done      one-cycle completion pulse
//   req_err       one-cycle timeout-abort pulse
//   sd_lba        LBA to hps_io
//   sd_rd/sd_wr   one-hot (or zero) strobes to hps_io
//   sd_ack        acknowledge from hps_io
//   sd_buff_din   granted slot's write data, 0 when idle
//   busy          high in any state except IDLE
//   grant         index of the current or last granted slot
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | searching for a pending request, starting after last grant
// ISSUE   | strobe asserted, waiting for sd_ack to rise
// XFER    | transfer in progress, waiting for sd_ack to fall
// DONE    | req_done pulse, last grant recorded, slot masked one cycle

module sd_req_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [23:0] TIMEOUT = 24'd8000000,
  localparam int         GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [32*NREQ-1:0]  req_lba,
  input  logic [NREQ-1:0]     req_rd,
  input  logic [NREQ-1:0]     req_wr,
  input  logic [8*NREQ-1:0]   req_buff_din,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     req_done,
  output logic [NREQ-1:0]     req_err,
  output logic [31:0]         sd_lba,
  output logic [NREQ-1:0]     sd_rd,
  output logic [NREQ-1:0]     sd_wr,
  input  logic                sd_ack,
  output logic [7:0]          sd_buff_din,
  output logic                busy,
  output logic [GW-1:0]       grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_grant_q;
  logic [NREQ-1:0] mask_q;
  logic            dir_rd_q;
  logic [31:0]     sd_lba_q;

  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] gnt_oh;
  logic            win;
  logic [GW-1:0]   win_idx;
  logic            active;
  logic            abort;

`ifdef SDARB_TIMEOUT_EN
  logic [23:0]     cnt_q;
`endif

  assign gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
  assign active = (state_q == S_ISSUE) || (state_q == S_XFER);

  // Round-robin search, starting at the slot after the last grant.
  always_comb begin
    int idx;
    idx     = 0;
    pending = (req_rd | req_wr) & ~mask_q;
    win     = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(last_grant_q) + 1 + k) % NREQ;
      if (!win && pending[idx]) begin
        win     = 1'b1;
        win_idx = GW'(idx);
      end
    end
  end

`ifdef SDARB_TIMEOUT_EN
  // The counter is 0 on the first ISSUE cycle, so the abort fires on the
  // TIMEOUT-th cycle after issue.
  assign abort = active && (cnt_q == TIMEOUT - 24'd1);
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win) state_d = S_ISSUE;
      S_ISSUE: begin
        if (abort)       state_d = S_IDLE;
        else if (sd_ack) state_d = S_XFER;
      end
      S_XFER: begin
        if (abort)        state_d = S_IDLE;
        else if (!sd_ack) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state. An asynchronous reset
  // therefore drops the strobes and acknowledges immediately.
  always_comb begin
    sd_rd       = '0;
    sd_wr       = '0;
    req_ack     = '0;
    req_done    = '0;
    req_err     = '0;
    sd_buff_din = 8'h00;
    if (state_q == S_ISSUE) begin
      if (dir_rd_q) sd_rd = gnt_oh;
      else          sd_wr = gnt_oh;
    end
    // An ack seen while the strobe is still up already belongs to this
    // transfer, so the granted slot sees it from its first cycle.
    if (active && sd_ack) req_ack = gnt_oh;
    if (state_q == S_DONE) req_done = gnt_oh;
    if (abort) req_err = gnt_oh;
    if (state_q != S_IDLE) sd_buff_din = req_buff_din[8*int'(grant_q) +: 8];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NREQ - 1);
      mask_q       <= '0;
      dir_rd_q     <= 1'b0;
      sd_lba_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      // The mask lasts for exactly one IDLE cycle. That covers a requester
      // that is still dropping its level the cycle after req_done.
      mask_q  <= '0;
      if (state_q == S_IDLE && win) begin
        grant_q  <= win_idx;
        dir_rd_q <= req_rd[win_idx];
        sd_lba_q <= req_lba[32*int'(win_idx) +: 32];
      end
      if (state_q == S_DONE || abort) begin
        last_grant_q <= grant_q;
        mask_q       <= gnt_oh;
      end
    end
  end

`ifdef SDARB_TIMEOUT_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                 cnt_q <= 24'd0;
    else if (state_q == S_IDLE) cnt_q <= 24'd0;
    else if (active)           cnt_q <= cnt_q + 24'd1;
  end
`endif

  assign sd_lba = sd_lba_q;
  assign busy   = (state_q != S_IDLE);
  assign grant  = grant_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
module tb_sd_req_arbiter;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic [127:0] req_lba;
  logic [3:0]   req_rd;
  logic [3:0]   req_wr;
  logic [31:0]  req_buff_din;
  logic [3:0]   req_ack;
  logic [3:0]   req_done;
  logic [3:0]   req_err;
  logic [31:0]  sd_lba;
  logic [3:0]   sd_rd;
  logic [3:0]   sd_wr;
  logic         sd_ack;
  logic [7:0]   sd_buff_din;
  logic         busy;
  logic [1:0]   grant;

  int n_checks = 0;
  int n_fail   = 0;

  sd_req_arbiter #(.NREQ(4), .TIMEOUT(24'd100)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req_lba      (req_lba),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_buff_din (req_buff_din),
    .req_ack      (req_ack),
    .req_done     (req_done),
    .req_err      (req_err),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .busy         (busy),
    .grant        (grant)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 ns after the rising edge, and checks follow 1 ns later.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    req_lba      = '0;
    req_rd       = '0;
    req_wr       = '0;
    req_buff_din = '0;
    sd_ack       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (sd_rd !== 4'b0)     begin n_fail++; $display("FAIL reset_sd_rd: got %b want 0000", sd_rd); end
    n_checks++; if (sd_wr !== 4'b0)     begin n_fail++; $display("FAIL reset_sd_wr: got %b want 0000", sd_wr); end
    n_checks++; if (sd_lba !== 32'h0)   begin n_fail++; $display("FAIL reset_sd_lba: got %h want 0", sd_lba); end
    n_checks++; if (grant !== 2'd0)     begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant); end
    n_checks++; if (req_done !== 4'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0000", req_done); end
    n_checks++; if (req_err !== 4'b0)   begin n_fail++; $display("FAIL reset_err: got %b want 0000", req_err); end
    n_checks++; if (sd_buff_din !== 8'h0) begin n_fail++; $display("FAIL reset_buff: got %h want 00", sd_buff_din); end
  endtask

  task automatic test_single_read();
    int bad;
    bad = 0;
    req_rd = 4'b0100;
    req_lba[95:64] = 32'h0000_1234;
    tick();
    n_checks++; if (sd_rd !== 4'b0100)    begin n_fail++; $display("FAIL single_sd_rd: got %b want 0100", sd_rd); end
    n_checks++; if (sd_wr !== 4'b0000)    begin n_fail++; $display("FAIL single_sd_wr: got %b want 0000", sd_wr); end
    n_checks++; if (sd_lba !== 32'h1234)  begin n_fail++; $display("FAIL single_sd_lba: got %h want 1234", sd_lba); end
    n_checks++; if (grant !== 2'd2)       begin n_fail++; $display("FAIL single_grant: got %0d want 2", grant); end
    sd_ack = 1'b1;
    #1;
    n_checks++; if (req_ack !== 4'b0100)  begin n_fail++; $display("FAIL single_ack_rise: got %b want 0100", req_ack); end
    tick();
    n_checks++; if (sd_rd !== 4'b0000)    begin n_fail++; $display("FAIL single_strobe_drop: got %b want 0000", sd_rd); end
    for (int i = 0; i < 511; i++) begin
      if (req_ack !== 4'b0100 || req_done !== 4'b0) bad++;
      if (i < 510) tick();
    end
    n_checks++; if (bad !== 0)            begin n_fail++; $display("FAIL single_ack_mirror: got %0d bad cycles want 0", bad); end
    sd_ack = 1'b0;
    #1;
    n_checks++; if (req_ack !== 4'b0000)  begin n_fail++; $display("FAIL single_ack_fall: got %b want 0000", req_ack); end
    n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL single_done_early: got %b want 0000", req_done); end
    tick();
    n_checks++; if (req_done !== 4'b0100) begin n_fail++; $display("FAIL single_done: got %b want 0100", req_done); end
    req_rd = 4'b0000;
    tick();
    n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL single_done_width: got %b want 0000", req_done); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL single_idle: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) req_lba[32*i +: 32] = 32'h100 + i;
    req_rd = 4'hF;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      n_checks++; if (sd_rd !== exp)      begin n_fail++; $display("FAIL rr_sd_rd[%0d]: got %b want %b", k, sd_rd, exp); end
      n_checks++; if (grant !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, grant, k % 4); end
      n_checks++; if (sd_lba !== 32'h100 + 32'(k % 4)) begin n_fail++; $display("FAIL rr_lba[%0d]: got %h want %h", k, sd_lba, 32'h100 + 32'(k % 4)); end
      sd_ack = 1'b1;
      tick();
      sd_ack = 1'b0;
      tick();
      n_checks++; if (req_done !== exp)   begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", k, req_done, exp); end
      if (k == 4) req_rd = 4'h0;
      tick();
      tick();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_end_idle: got %b want 0", busy); end
  endtask

  task automatic test_rd_wr_same_slot();
    req_rd = 4'b0010;
    req_wr = 4'b0010;
    tick();
    n_checks++; if (sd_rd !== 4'b0010) begin n_fail++; $display("FAIL rdwr_sd_rd: got %b want 0010", sd_rd); end
    n_checks++; if (sd_wr !== 4'b0000) begin n_fail++; $display("FAIL rdwr_sd_wr: got %b want 0000", sd_wr); end
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    n_checks++; if (req_done !== 4'b0010) begin n_fail++; $display("FAIL rdwr_done: got %b want 0010", req_done); end
    req_rd = 4'b0;
    req_wr = 4'b0;
    tick();
  endtask

  task automatic test_buffer_routing();
    req_wr       = 4'b1001;
    req_buff_din = 32'hA500_005A;
    #1;
    n_checks++; if (sd_buff_din !== 8'h00) begin n_fail++; $display("FAIL buf_idle0: got %h want 00", sd_buff_din); end
    tick();
    n_checks++; if (grant !== 2'd3)        begin n_fail++; $display("FAIL buf_grant: got %0d want 3", grant); end
    n_checks++; if (sd_wr !== 4'b1000)     begin n_fail++; $display("FAIL buf_sd_wr: got %b want 1000", sd_wr); end
    n_checks++; if (sd_buff_din !== 8'hA5) begin n_fail++; $display("FAIL buf_din3: got %h want a5", sd_buff_din); end
    sd_ack = 1'b1;
    #1;
    n_checks++; if (req_ack !== 4'b1000)   begin n_fail++; $display("FAIL buf_ack_issue: got %b want 1000", req_ack); end
    tick();
    n_checks++; if (req_ack !== 4'b1000)   begin n_fail++; $display("FAIL buf_ack_xfer: got %b want 1000", req_ack); end
    n_checks++; if (sd_buff_din !== 8'hA5) begin n_fail++; $display("FAIL buf_din3_xfer: got %h want a5", sd_buff_din); end
    sd_ack = 1'b0;
    tick();
    n_checks++; if (req_done !== 4'b1000)  begin n_fail++; $display("FAIL buf_done3: got %b want 1000", req_done); end
    req_wr = 4'b0001;
    tick();
    n_checks++; if (sd_buff_din !== 8'h00) begin n_fail++; $display("FAIL buf_idle1: got %h want 00", sd_buff_din); end
    tick();
    n_checks++; if (sd_wr !== 4'b0001)     begin n_fail++; $display("FAIL buf_sd_wr0: got %b want 0001", sd_wr); end
    n_checks++; if (sd_buff_din !== 8'h5A) begin n_fail++; $display("FAIL buf_din0: got %h want 5a", sd_buff_din); end
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    n_checks++; if (req_done !== 4'b0001)  begin n_fail++; $display("FAIL buf_done0: got %b want 0001", req_done); end
    req_wr = 4'b0;
    tick();
  endtask

  task automatic test_reset_mid_xfer();
    apply_reset();
    req_wr = 4'b1000;
    tick();
    n_checks++; if (sd_wr !== 4'b1000)   begin n_fail++; $display("FAIL rst_mid_issue: got %b want 1000", sd_wr); end
    sd_ack = 1'b1;
    tick();
    n_checks++; if (req_ack !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_ack: got %b want 1000", req_ack); end
    reset = 1'b1;
    #1;
    n_checks++; if (sd_wr !== 4'b0000)   begin n_fail++; $display("FAIL rst_mid_sd_wr: got %b want 0000", sd_wr); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_checks++; if (grant !== 2'd0)      begin n_fail++; $display("FAIL rst_mid_grant: got %0d want 0", grant); end
    n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_req_ack: got %b want 0000", req_ack); end
    tick();
    n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0000", req_done); end
    sd_ack = 1'b0;
    req_wr = 4'b0;
    reset  = 1'b0;
    req_rd = 4'b1001;
    tick();
    n_checks++; if (sd_rd !== 4'b0001)   begin n_fail++; $display("FAIL rst_first_slot: got %b want 0001", sd_rd); end
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    req_rd = 4'b0;
    tick();
  endtask

  task automatic test_stray_ack();
    sd_ack = 1'b1;
    #1;
    n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL stray_ack: got %b want 0000", req_ack); end
    tick();
    tick();
    tick();
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL stray_busy: got %b want 0", busy); end
    n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL stray_done: got %b want 0000", req_done); end
    sd_ack = 1'b0;
    tick();
  endtask

`ifdef SDARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int errs;
    int dones;
    n = 0; errs = 0; dones = 0;
    apply_reset();
    req_rd = 4'b0010;
    tick();
    while (sd_rd === 4'b0010 && n < 200) begin
      if (req_err === 4'b0010) errs++;
      if (req_done !== 4'b0000) dones++;
      n++;
      tick();
    end
    n_checks++; if (n !== 100)   begin n_fail++; $display("FAIL to_strobe_cycles: got %0d want 100", n); end
    n_checks++; if (errs !== 1)  begin n_fail++; $display("FAIL to_err_pulses: got %0d want 1", errs); end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL to_done_pulses: got %0d want 0", dones); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b want 0", busy); end
    n_checks++; if (req_err !== 4'b0000) begin n_fail++; $display("FAIL to_err_width: got %b want 0000", req_err); end
    req_rd = 4'b0;
    sd_ack = 1'b1;
    #1;
    n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL to_late_ack: got %b want 0000", req_ack); end
    tick();
    sd_ack = 1'b0;
    tick();
    n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL to_late_done: got %b want 0000", req_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_rd_wr_same_slot();
    test_buffer_routing();
    test_reset_mid_xfer();
    test_stray_ack();
`ifdef SDARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Shares the single HPS virtual-disk channel (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_din) between the four image requesters of the X68000 core: FDD0, FDD1, SASI, SRAM. It round-robin arbitrates pending sector requests and presents the winner's LBA and read/write strobe to hps_io. It gates sd_ack and the buffer write-data path to the granted requester only, and returns a one-cycle completion pulse. It sits between X68MiSTer and hps_io in the emu top, in the clk_sys domain.

## Interface
- NREQ, 4, number of requesters; index = hps_io VDNUM slot (0 FDD0, 1 FDD1, 2 SASI, 3 SRAM)
- TIMEOUT, 24'd8000000, clk_sys cycles allowed from issue to ack fall (used only with SDARB_TIMEOUT_EN)

- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_lba  in  32*NREQ  per-requester sector LBA, slot i at [32i+31:32i]
- req_rd  in  NREQ  read request level, held until req_done
- req_wr  in  NREQ  write request level, held until req_done
- req_buff_din  in  8*NREQ  per-requester write data for the HPS buffer
- req_ack  out  NREQ  sd_ack routed to granted slot only
- req_done  out  NREQ  one-cycle completion pulse
- req_err  out  NREQ  one-cycle timeout-abort pulse
- sd_lba  out  32  to hps_io
- sd_rd  out  NREQ  to hps_io, one-hot or zero
- sd_wr  out  NREQ  to hps_io, one-hot or zero
- sd_ack  in  1  from hps_io
- sd_buff_din  out  8  to hps_io; req_buff_din of granted slot, 0 when idle
- busy  out  1  high in any state except IDLE
- grant  out  2  index of current/last granted slot

## Operation
- States: IDLE, ISSUE, XFER, DONE.
- IDLE: pending(i) = (req_rd[i] | req_wr[i]) & ~mask[i].
  - Search order starts at last_grant+1 mod NREQ. The first pending slot wins.
  - On a win: latch grant, sd_lba <= req_lba[grant], dir = read if req_rd set (read beats write when both are set). Go to ISSUE.
- ISSUE: sd_rd[grant] or sd_wr[grant] asserted.
  - On sampled sd_ack=1, clear the strobe and go to XFER.
- XFER: req_ack[grant] follows sd_ack combinationally. On sampled sd_ack=0, go to DONE.
- DONE: req_done[grant]=1 for one cycle. last_grant <= grant. mask[grant] set for the next IDLE cycle only. Go to IDLE.
- Requester deasserts rd/wr no later than the cycle after req_done. The mask guarantees no double grant.
- Requester inputs are ignored after latch. Withdrawing a request mid-operation does not abort it; the transaction completes and req_done still pulses.
- req_ack, sd_buff_din and the strobes of non-granted slots are always 0.
- sd_ack high while in IDLE (stray) is ignored.
- Reset values: state IDLE, sd_rd=0, sd_wr=0, sd_lba=0, req_done=0, req_err=0, busy=0, grant=0, last_grant=NREQ-1 so slot 0 is first, mask=0.
- Reset mid-transaction drops the strobe immediately (asynchronous). No done or err pulse is emitted.

## Timing
- Request sampled in IDLE at cycle N: strobe and sd_lba registered-valid at N+1.
- sd_ack rise sampled at cycle M: strobe low at M+1.
- sd_ack fall sampled at cycle K: req_done at K+1. Earliest next strobe is at K+3 (DONE at K+1, IDLE at K+2).
- Minimum transaction length is 4 cycles plus the sd_ack high time.
- An ack that rises and falls between samples (sub-cycle) cannot occur; sd_ack is clk_sys-synchronous.

## Configuration
- SDARB_TIMEOUT_EN defined:
  - A 24-bit counter clears on entry to ISSUE and increments in ISSUE/XFER.
  - At TIMEOUT-1 the block drops the strobe, pulses req_err[grant] (no req_done), updates last_grant, sets mask, and returns to IDLE.
  - Any later sd_ack is ignored in IDLE.
- Undefined: no counter; req_err tied to 0; the block waits indefinitely for sd_ack.

## Test plan
- Single read: req_rd[2]=1, lba=0x1234 -> sd_rd=4'b0100 and sd_lba=0x1234 next cycle. Ack held 512 cycles -> req_ack[2] mirrors it. req_done[2] pulses 1 cycle after ack fall.
- Round-robin: all four request reads continuously -> grants issued in order 0,1,2,3,0 with no slot granted twice in a row.
- Read/write same slot: req_rd[1]=req_wr[1]=1 -> sd_rd=4'b0010 and sd_wr=0.
- Buffer routing: slot 3 granted, req_buff_din slot 3 = 0xA5, slot 0 = 0x5A -> sd_buff_din=0xA5; req_ack[0] stays 0 throughout.
- Reset mid-XFER: assert reset while sd_ack=1 -> sd_wr=0, busy=0, grant=0 at once. After release, a slot-0 request is served first.
- SDARB_TIMEOUT_EN, TIMEOUT=100: no ack -> strobe drops after exactly 100 cycles in ISSUE, req_err pulses 1 cycle, req_done never pulses; a late sd_ack produces no req_ack.
